pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Reset sequencer that sits directly downstream of the 50→200 MHz PLL wrapper. It drives the PLL's active-high reset, watches its asynchronous `locked` output, and releases the system reset to the MIPS core only after lock has been continuously stable. On lock timeout it retries the PLL a bounded number of times before flagging failure. Runs entirely on the 50 MHz reference clock, because the PLL output clock is not trustworthy before lock.

## Interface
- `PLL_RST_CYCLES`, default 16: clocks for which `pll_rst` is held high per attempt (≥2).
- `LOCK_TIMEOUT`, default 65536: clocks allowed in WAIT_LOCK before an attempt is declared failed.
- `STABLE_CYCLES`, default 1024: consecutive synchronized-lock clocks required before release.
- `MAX_RETRIES`, default 3: timeouts tolerated before FAIL.
- `clk`, in, 1: 50 MHz reference clock (the same net as the PLL `refclk`).
- `rst_n`, in, 1: asynchronous active-low reset.
- `locked`, in, 1: PLL lock, asynchronous to `clk`.
- `restart`, in, 1: synchronous single-cycle request to restart the sequence.
- `pll_rst`, out, 1: active-high reset to the PLL.
- `sys_rst_n`, out, 1: active-low system reset to downstream logic. Each consuming clock domain re-synchronizes it.
- `ready`, out, 1: high in RUN.
- `fail`, out, 1: high in FAIL.
- `retry_cnt`, out, 2: timeouts in the current sequence.
- `lock_loss_cnt`, out, 8: saturating count of lock drops seen while in RUN.

## Operation
- `locked` passes through a 2-flop synchronizer to produce `locked_s`. All decisions use `locked_s` only.
- A single counter `cnt` is cleared on every state entry.
- **PLL_RESET**
  - `pll_rst` = 1.
  - Go to WAIT_LOCK when `cnt` == `PLL_RST_CYCLES`-1.
- **WAIT_LOCK**
  - `pll_rst` = 0.
  - If `locked_s` is high, go to STABLE.
  - Otherwise, when `cnt` == `LOCK_TIMEOUT`-1:
    - if `retry_cnt` == `MAX_RETRIES`, go to FAIL;
    - else increment `retry_cnt` and go to PLL_RESET.
- **STABLE**
  - If `locked_s` is low, go back to WAIT_LOCK. The timeout restarts from 0.
  - Otherwise, when `cnt` == `STABLE_CYCLES`-1, go to RUN and clear `retry_cnt`.
- **RUN**
  - `sys_rst_n` = 1 and `ready` = 1.
  - If `locked_s` is low: increment `lock_loss_cnt` (saturating at 255) and go to PLL_RESET.
- **FAIL**
  - `fail` = 1, `pll_rst` = 0, `sys_rst_n` = 0.
  - Exits only via `restart` or `rst_n`.
- **restart**
  - From any state, `restart` goes to PLL_RESET and clears `retry_cnt`.
  - `restart` has priority over every other transition in the same cycle.
- **Outputs** are Moore decodes of the registered state, registered so they are glitch-free.
- **Reset values:** state = PLL_RESET, `cnt` = 0, `pll_rst` = 1, `sys_rst_n` = 0, `ready` = 0, `fail` = 0, `retry_cnt` = 0, `lock_loss_cnt` = 0, synchronizer flops = 0.

## Timing
- **Synchronizer latency:** 2 clocks from a `locked` edge to a `locked_s` edge.
- **Power-up `pll_rst`:**
  - `pll_rst` is high during reset.
  - It stays high for exactly `PLL_RST_CYCLES` clocks after `rst_n` deasserts.
  - It falls one clock after the terminal count.
- **Release latency:** with `locked` rising before edge 1 during WAIT_LOCK, `sys_rst_n` goes high after edge `STABLE_CYCLES`+3.
- **Lock loss in RUN:**
  - `sys_rst_n` falls after the edge following `locked_s` falling, i.e. 3 edges after the `locked` fall.
  - `pll_rst` rises at the same edge.
- **Counter width:** `cnt` is `$clog2` of the maximum of the three cycle parameters.
- **Reset mid-operation:** asynchronous assertion drives the outputs to their reset values immediately.
- **Glitches:** a `locked` pulse shorter than 1 clock may be missed. A drop of at least 2 clocks is always seen.

## Structure
- **Package `pll_seq_pkg`:**
  - state enum: PLL_RESET, WAIT_LOCK, STABLE, RUN, FAIL;
  - `LOCK_LOSS_MAX` = 255;
  - counter-width helper function.
- **Sub-module `sync_2ff`:** a parameterizable-width 2-flop synchronizer with an async active-low reset. Reuse it for other asynchronous inputs.

## Test plan
Parameters for all scenarios: `PLL_RST_CYCLES`=4, `STABLE_CYCLES`=8, `LOCK_TIMEOUT`=32, `MAX_RETRIES`=2.

1. **Normal lock:** release reset, raise `locked` 10 clocks later.
   - `pll_rst` is high for exactly 4 clocks.
   - `sys_rst_n` and `ready` rise 11 edges after `locked` rises.
   - `retry_cnt` = 0.
2. **Unstable lock:** `locked` high for 5 clocks, low for 3, then high.
   - `sys_rst_n` stays 0 through the glitch.
   - Release comes 11 edges after the final rise.
   - No `pll_rst` pulse occurs.
3. **Timeout and retry:** hold `locked` low.
   - `pll_rst` pulses 4 clocks wide, spaced 32 WAIT_LOCK clocks apart.
   - `retry_cnt` steps 1, 2.
   - After the third timeout `fail` = 1, `pll_rst` = 0, `sys_rst_n` = 0.
   - A `restart` pulse gives `retry_cnt` = 0 and `pll_rst` = 1 on the next edge.
4. **Lock loss in RUN:** drop `locked` for 4 clocks.
   - `sys_rst_n` falls 3 edges after the drop.
   - `lock_loss_cnt` = 1.
   - A full PLL_RESET → RUN sequence follows.
   - After 256 drops, `lock_loss_cnt` holds at 255.
5. **Async reset mid-STABLE:** assert `rst_n` between clock edges.
   - All outputs take their reset values immediately.
   - `pll_rst` = 1 without waiting for a clock edge.
6. **restart collision:** `restart` in the same cycle as the STABLE terminal count.
   - Next state is PLL_RESET, not RUN.
   - `sys_rst_n` never pulses high.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding, limits and counter sizing for the PLL lock sequencer.
package pll_seq_pkg;
  typedef enum logic [2:0] {PLL_RESET, WAIT_LOCK, STABLE, RUN, FAIL} state_t;
  localparam int LOCK_LOSS_MAX = 255;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// sync_2ff: width-parameterized two-flop synchronizer with async active-low reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: holds the PLL in reset, waits for stable lock, then releases the system reset.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);
  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  state_t state, next;
  logic [CW-1:0] cnt;
  logic locked_s;
  logic [1:0] retry_nxt;
  logic [7:0] loss_nxt;
  sync_2ff #(.W(1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (locked),
    .q    (locked_s)
  );
  always_comb begin
    next      = state;
    retry_nxt = retry_cnt;
    loss_nxt  = lock_loss_cnt;
    case (state)
      PLL_RESET: if (cnt == CW'(PLL_RST_CYCLES - 1)) next = WAIT_LOCK;
      WAIT_LOCK:
        if (locked_s) next = STABLE;
        else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          if (retry_cnt == 2'(MAX_RETRIES)) next = FAIL;
          else begin
            retry_nxt = retry_cnt + 2'd1;
            next      = PLL_RESET;
          end
        end
      STABLE:
        if (!locked_s) next = WAIT_LOCK;
        else if (cnt == CW'(STABLE_CYCLES - 1)) begin
          next      = RUN;
          retry_nxt = '0;
        end
      RUN:
        if (!locked_s) begin
          next     = PLL_RESET;
          loss_nxt = lock_loss_cnt == 8'(LOCK_LOSS_MAX) ? lock_loss_cnt : lock_loss_cnt + 8'd1;
        end
      FAIL:    next = FAIL;
      default: next = PLL_RESET;
    endcase
    // restart overrides every transition decided above, including the loss count
    if (restart) begin
      next      = PLL_RESET;
      retry_nxt = '0;
      loss_nxt  = lock_loss_cnt;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= PLL_RESET;
      cnt   <= '0;
    end else begin
      state <= next;
      cnt   <= (restart || next != state) ? '0 : cnt + CW'(1);
    end
  // outputs decode the next state into flops so they change with the state register, glitch-free
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pll_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
      ready         <= 1'b0;
      fail          <= 1'b0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
    end else begin
      pll_rst       <= next == PLL_RESET;
      sys_rst_n     <= next == RUN;
      ready         <= next == RUN;
      fail          <= next == FAIL;
      retry_cnt     <= retry_nxt;
      lock_loss_cnt <= loss_nxt;
    end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: scenario tasks with a queue of expected edge counts for the lock sequencer.
module tb_pll_lock_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic locked = 1'b0;
  logic restart = 1'b0;
  logic pll_rst, sys_rst_n, ready, fail;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  typedef struct {string name; int val;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .locked       (locked),
    .restart      (restart),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .fail         (fail),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int c);
    return c == 0 ? pll_rst : c == 1 ? sys_rst_n : c == 2 ? fail : ready;
  endfunction

  // edges until signal c reaches lvl; -1 when the budget runs out
  task automatic wait_sig(input int c, input logic lvl, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (sig(c) === lvl) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic push(input string name, input int val);
    sb.push_back('{name, val});
  endtask

  task automatic start_seq();
    rst_n = 1'b0;
    locked = 1'b0;
    restart = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    exp_t e;
    int n;
    rst_n = 1'b0;
    locked = 1'b0;
    restart = 1'b0;
    repeat (2) tick();
    checks++;
    if ({pll_rst, sys_rst_n, ready, fail, retry_cnt, lock_loss_cnt} !== 14'b1000_00_00000000) begin
      failures++;
      $display("FAIL reset_values: got %b expected %b", {pll_rst, sys_rst_n, ready, fail, retry_cnt, lock_loss_cnt}, 14'b1000_00_00000000);
    end
    rst_n = 1'b1;
    push("pll_rst_width", 4);
    wait_sig(0, 1'b0, 20, n);
    e = sb.pop_front();
    checks++;
    if (n !== e.val) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", e.name, n, e.val);
    end
  endtask

  task automatic test_normal_lock();
    exp_t e;
    int n;
    start_seq();
    repeat (6) tick();
    locked = 1'b1;
    push("release_latency", 11);
    wait_sig(1, 1'b1, 30, n);
    e = sb.pop_front();
    checks++;
    if (n !== e.val) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", e.name, n, e.val);
    end
    checks++;
    if ({ready, retry_cnt, pll_rst} !== 4'b1_00_0) begin
      failures++;
      $display("FAIL run_outputs: got %b expected %b", {ready, retry_cnt, pll_rst}, 4'b1_00_0);
    end
  endtask

  task automatic test_unstable_lock();
    exp_t e;
    int n;
    logic sys_seen, pll_seen;
    sys_seen = 1'b0;
    pll_seen = 1'b0;
    start_seq();
    locked = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) locked = 1'b0;
      tick();
      sys_seen |= sys_rst_n;
      pll_seen |= pll_rst;
    end
    locked = 1'b1;
    checks++;
    if ({sys_seen, pll_seen} !== 2'b00) begin
      failures++;
      $display("FAIL glitch_quiet: got sys/pll seen %b expected %b", {sys_seen, pll_seen}, 2'b00);
    end
    push("release_after_glitch", 11);
    wait_sig(1, 1'b1, 30, n);
    e = sb.pop_front();
    checks++;
    if (n !== e.val) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", e.name, n, e.val);
    end
  endtask

  task automatic test_timeout_retry();
    exp_t e;
    int n;
    start_seq();
    for (int r = 1; r <= 2; r++) begin
      push("timeout_gap", 32);
      wait_sig(0, 1'b1, 40, n);
      e = sb.pop_front();
      checks++;
      if (n !== e.val) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", e.name, n, e.val);
      end
      checks++;
      if (retry_cnt !== 2'(r)) begin
        failures++;
        $display("FAIL retry_step: got %0d expected %0d", retry_cnt, r);
      end
      push("retry_pulse", 4);
      wait_sig(0, 1'b0, 10, n);
      e = sb.pop_front();
      checks++;
      if (n !== e.val) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", e.name, n, e.val);
      end
    end
    push("fail_gap", 32);
    wait_sig(2, 1'b1, 40, n);
    e = sb.pop_front();
    checks++;
    if (n !== e.val) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", e.name, n, e.val);
    end
    repeat (5) tick();
    checks++;
    if ({fail, pll_rst, sys_rst_n, ready, retry_cnt} !== 6'b1000_10) begin
      failures++;
      $display("FAIL fail_hold: got %b expected %b", {fail, pll_rst, sys_rst_n, ready, retry_cnt}, 6'b1000_10);
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if ({fail, pll_rst, retry_cnt} !== 4'b01_00) begin
      failures++;
      $display("FAIL restart_from_fail: got %b expected %b", {fail, pll_rst, retry_cnt}, 4'b01_00);
    end
  endtask

  task automatic test_lock_loss();
    exp_t e;
    int n, lost;
    lost = 0;
    start_seq();
    locked = 1'b1;
    push("run_entry", 11);
    wait_sig(1, 1'b1, 30, n);
    e = sb.pop_front();
    checks++;
    if (n !== e.val) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", e.name, n, e.val);
    end
    locked = 1'b0;
    push("loss_fall", 3);
    wait_sig(1, 1'b0, 10, n);
    e = sb.pop_front();
    checks++;
    if (n !== e.val) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", e.name, n, e.val);
    end
    checks++;
    if ({pll_rst, ready, lock_loss_cnt} !== 10'b1_0_00000001) begin
      failures++;
      $display("FAIL loss_outputs: got %b expected %b", {pll_rst, ready, lock_loss_cnt}, 10'b1_0_00000001);
    end
    tick();
    locked = 1'b1;
    push("loss_pll_rst_fall", 3);
    wait_sig(0, 1'b0, 10, n);
    e = sb.pop_front();
    checks++;
    if (n !== e.val) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", e.name, n, e.val);
    end
    push("relock_release", 9);
    wait_sig(1, 1'b1, 30, n);
    e = sb.pop_front();
    checks++;
    if (n !== e.val) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", e.name, n, e.val);
    end
    for (int d = 2; d <= 255; d++) begin
      locked = 1'b0;
      repeat (4) tick();
      locked = 1'b1;
      wait_sig(3, 1'b1, 40, n);
      if (n < 0) lost++;
    end
    checks++;
    if ({lost, lock_loss_cnt} !== {32'd0, 8'd255}) begin
      failures++;
      $display("FAIL loss_count_255: got lost=%0d cnt=%0d expected lost=0 cnt=255", lost, lock_loss_cnt);
    end
    locked = 1'b0;
    repeat (4) tick();
    locked = 1'b1;
    checks++;
    if (lock_loss_cnt !== 8'd255) begin
      failures++;
      $display("FAIL loss_saturate: got %0d expected 255", lock_loss_cnt);
    end
  endtask

  task automatic test_async_reset();
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pll_rst, sys_rst_n, ready, fail, retry_cnt, lock_loss_cnt} !== 14'b1000_00_00000000) begin
      failures++;
      $display("FAIL async_reset: got %b expected %b", {pll_rst, sys_rst_n, ready, fail, retry_cnt, lock_loss_cnt}, 14'b1000_00_00000000);
    end
  endtask

  task automatic test_restart_collision();
    exp_t e;
    int n;
    logic sys_seen;
    sys_seen = 1'b0;
    start_seq();
    locked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      sys_seen |= sys_rst_n;
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if ({pll_rst, sys_rst_n, ready, sys_seen} !== 4'b1000) begin
      failures++;
      $display("FAIL restart_priority: got %b expected %b", {pll_rst, sys_rst_n, ready, sys_seen}, 4'b1000);
    end
    push("restart_release", 13);
    wait_sig(1, 1'b1, 30, n);
    e = sb.pop_front();
    checks++;
    if (n !== e.val) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", e.name, n, e.val);
    end
  endtask

  initial begin
    test_reset();
    test_normal_lock();
    test_unstable_lock();
    test_timeout_retry();
    test_lock_loss();
    test_async_reset();
    test_restart_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
